led_blink_arbiter: RTL and testbench

Shares the single board LED between up to NREQ requesters, each asking to flash a blink code of N pulses. A round-robin arbiter grants the LED to one requester at a time, and a phase FSM sequences the ON/OFF/GAP timing. Timing comes from an internal tick prescaler clocked by the HSOSC clock. The block replaces the free-running divider-to-LED path in top: top wires the oscillator clock and nreset in, and led out to the pin.

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/led_blink_arbiter.sv | 175 +++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and default timing for the LED blink arbiter.
package led_ctrl_pkg;

  // Blink sequencer phases
  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff,
    StGap
  } led_state_e;

  // Defaults assume a 24 MHz oscillator and a 1 ms tick
  localparam int unsigned DefNreq     = 4;
  localparam int unsigned DefCntW     = 4;
  localparam int unsigned DefTickDiv  = 24000;
  localparam int unsigned DefOnTicks  = 200;
  localparam int unsigned DefOffTicks = 200;
  localparam int unsigned DefGapTicks = 1000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider producing a one-cycle tick every TICK_DIV cycles.
module tick_prescaler
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  // Count up, wrap on tick; clr restarts the phase from zero
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED between NREQ requesters, each flashing a blink code.
module led_blink_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = DefNreq,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned TICK_DIV  = DefTickDiv,
  parameter int unsigned ON_TICKS  = DefOnTicks,
  parameter int unsigned OFF_TICKS = DefOffTicks,
  parameter int unsigned GAP_TICKS = DefGapTicks
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] blink_cnt,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  localparam int unsigned IdxW     = $clog2(NREQ);
  localparam int unsigned MaxTicks = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam int unsigned TickW    = $clog2(MaxTicks + 1);

  led_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [IdxW-1:0]  cur_q, cur_d;
  logic [TickW-1:0] tcnt_q, tcnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;

  logic             tick;
  logic             clr;
  logic             phase_end;
  int unsigned      phase_lim;
  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;
  logic [CNT_W-1:0] cnt_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign cnt_arr[g] = blink_cnt[g*CNT_W +: CNT_W];
  end

  // Prescaler restarts on every state change so phases are exact multiples of TICK_DIV
  assign clr = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .nreset(nreset),
    .clr   (clr),
    .tick  (tick)
  );

  // Round-robin pick: first set req bit searching upward from last_q+1
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!pick_valid && req[IdxW'((32'(last_q) + i) % NREQ)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'((32'(last_q) + i) % NREQ);
      end
    end
  end

  // Phase length in ticks for the current state
  always_comb begin
    phase_lim = 1;
    case (state_q)
      StOn:    phase_lim = ON_TICKS;
      StOff:   phase_lim = OFF_TICKS;
      StGap:   phase_lim = GAP_TICKS;
      default: phase_lim = 1;
    endcase
    phase_end = tick && (tcnt_q == TickW'(phase_lim - 1));
  end

  // Next-state and registered-output logic for the blink sequencer
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    last_d  = last_q;
    cur_d   = cur_q;
    tcnt_d  = tcnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    led_d   = led_q;

    if (tick && !phase_end) tcnt_d = tcnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (pick_valid) begin
          last_d = pick_idx;
          if (cnt_arr[pick_idx] != '0) begin
            rem_d           = cnt_arr[pick_idx];
            cur_d           = pick_idx;
            state_d         = StOn;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            led_d           = 1'b1;
            busy_d          = 1'b1;
          end else begin
            // Empty code: acknowledge without touching the LED
            done_d[pick_idx] = 1'b1;
          end
        end
      end
      StOn: begin
        if (phase_end) begin
          // rem is nonzero throughout a sequence, so this never wraps
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == CNT_W'(1)) ? StGap : StOff;
          led_d   = 1'b0;
        end
      end
      StOff: begin
        if (phase_end) begin
          state_d = StOn;
          led_d   = 1'b1;
        end
      end
      StGap: begin
        if (phase_end) begin
          state_d       = StIdle;
          gnt_d         = '0;
          done_d[cur_q] = 1'b1;
          busy_d        = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) tcnt_d = '0;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      last_q  <= IdxW'(NREQ - 1);
      cur_q   <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Scoreboard bench for led_blink_arbiter: stimulus queues expected grant/done events and
// LED levels, a monitor on the falling edge pops and compares them.
module tb_led_blink_arbiter;

  logic        clk;
  logic        nreset;
  logic [3:0]  req;
  logic [15:0] blink_cnt;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  typedef struct {
    bit       is_done;
    bit [3:0] vec;
    int       cyc;
  } ev_t;

  typedef struct {
    int cyc;
    bit val;
  } led_exp_t;

  ev_t      ev_q[$];
  led_exp_t led_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rises  = 0;
  int base;

  led_blink_arbiter #(
    .NREQ     (4),
    .CNT_W    (4),
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .GAP_TICKS(3)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .req      (req),
    .blink_cnt(blink_cnt),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .led      (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input bit d, input bit [3:0] v, input int c);
    ev_t e;
    e.is_done = d;
    e.vec     = v;
    e.cyc     = c;
    ev_q.push_back(e);
  endtask

  task automatic push_led(input int b, input int from, input int to, input bit v);
    led_exp_t l;
    for (int c = from; c <= to; c++) begin
      l.cyc = b + c;
      l.val = v;
      led_q.push_back(l);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_led"},  int'(led),  0);
    chk({tag, "_gnt"},  int'(gnt),  0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: compares DUT events and LED level against the scoreboard queues
  initial begin
    ev_t      e;
    led_exp_t l;
    logic [3:0] gnt_prev;
    logic       led_prev;
    gnt_prev = '0;
    led_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (led_q.size() > 0 && led_q[0].cyc == cyc) begin
        l = led_q.pop_front();
        chk("led_wave", int'(led), int'(l.val));
      end
      if (done != '0) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected at cycle %0d: got done=%b required none", cyc, done);
        end else begin
          e = ev_q.pop_front();
          chk("done_event_kind", int'(e.is_done), 1);
          chk("done_vec", int'(done), int'(e.vec));
          chk("done_cyc", cyc, e.cyc);
          chk("done_gnt_low", int'(gnt), 0);
          chk("done_led_low", int'(led), 0);
          chk("done_busy_low", int'(busy), 0);
        end
      end
      if (gnt != '0 && gnt_prev == '0) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gnt_unexpected at cycle %0d: got gnt=%b required none", cyc, gnt);
        end else begin
          e = ev_q.pop_front();
          chk("gnt_event_kind", int'(e.is_done), 0);
          chk("gnt_vec", int'(gnt), int'(e.vec));
          chk("gnt_cyc", cyc, e.cyc);
          chk("gnt_led_high", int'(led), 1);
          chk("gnt_busy_high", int'(busy), 1);
        end
      end
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      if (led && !led_prev) rises++;
      gnt_prev = gnt;
      led_prev = led;
    end
  end

  // Directed stimulus; cycle c of a test is label base+c
  initial begin
    nreset    = 1'b0;
    req       = 4'b1111;
    blink_cnt = 16'h1111;

    // Reset held three cycles with all requests high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle_outputs("reset");
    end
    base   = cyc;
    nreset = 1'b1;
    push_ev(1'b0, 4'b0001, base + 1);
    push_ev(1'b1, 4'b0001, base + 21);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 24);

    // Single request, count 2
    base      = cyc;
    req       = 4'b0001;
    blink_cnt = 16'h0002;
    push_ev(1'b0, 4'b0001, base + 1);
    push_ev(1'b1, 4'b0001, base + 33);
    push_led(base, 1, 8, 1'b1);
    push_led(base, 9, 12, 1'b0);
    push_led(base, 13, 20, 1'b1);
    push_led(base, 21, 33, 1'b0);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 36);

    // Reset pulse restores requester 0 priority
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Round-robin between requesters 0 and 2, count 1 each
    base      = cyc;
    req       = 4'b0101;
    blink_cnt = 16'h0101;
    push_ev(1'b0, 4'b0001, base + 1);
    push_ev(1'b1, 4'b0001, base + 21);
    push_ev(1'b0, 4'b0100, base + 22);
    push_ev(1'b1, 4'b0100, base + 42);
    push_ev(1'b0, 4'b0001, base + 43);
    push_ev(1'b1, 4'b0001, base + 63);
    push_ev(1'b0, 4'b0100, base + 64);
    push_ev(1'b1, 4'b0100, base + 84);
    wait_to(base + 84);
    req = 4'b0000;
    wait_to(base + 88);

    // Zero count on requester 1, then 1 and 2 together: 2 wins
    base      = cyc;
    req       = 4'b0010;
    blink_cnt = 16'h0100;
    push_ev(1'b1, 4'b0010, base + 1);
    wait_to(base + 1);
    req = 4'b0110;
    push_ev(1'b0, 4'b0100, base + 2);
    push_ev(1'b1, 4'b0100, base + 22);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 25);

    // Reset in the middle of a count-2 sequence
    base      = cyc;
    req       = 4'b0001;
    blink_cnt = 16'h0002;
    push_ev(1'b0, 4'b0001, base + 1);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 5);
    nreset = 1'b0;
    wait_to(base + 6);
    chk_idle_outputs("midrst");
    wait_to(base + 7);
    nreset = 1'b1;
    wait_to(base + 12);
    base      = cyc;
    req       = 4'b0001;
    blink_cnt = 16'h0001;
    push_ev(1'b0, 4'b0001, base + 1);
    push_ev(1'b1, 4'b0001, base + 21);
    push_led(base, 1, 8, 1'b1);
    push_led(base, 9, 9, 1'b0);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 24);

    // Maximum count on requester 3
    base      = cyc;
    req       = 4'b1000;
    blink_cnt = 16'hF000;
    rises     = 0;
    push_ev(1'b0, 4'b1000, base + 1);
    push_ev(1'b1, 4'b1000, base + 189);
    wait_to(base + 2);
    req = 4'b0000;
    wait_to(base + 195);
    chk("max_led_rises", rises, 15);
    chk("max_end_busy", int'(busy), 0);
    chk("max_end_led", int'(led), 0);

    chk("events_left", ev_q.size(), 0);
    chk("led_exp_left", led_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
